// File: rtl/decode_stage_hz.sv
`timescale 1ns/1ps
// decode_stage_hz: RV32I decode with register file, load-use hazard detection
// and a stallable/flushable ID/EX pipeline register.
module decode_stage_hz #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREGS  = 32,
   localparam int unsigned REG_AW = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       InstrD,
   input  logic [XLEN-1:0]   PCD,
   input  logic [XLEN-1:0]   PCPlus4D,
   input  logic              ValidD,
   input  logic              HoldE,
   input  logic              FlushE,
   input  logic              RegWriteW,
   input  logic [REG_AW-1:0] RdW,
   input  logic [XLEN-1:0]   ResultW,
   output logic [REG_AW-1:0] Rs1D,
   output logic [REG_AW-1:0] Rs2D,
   output logic              LoadUseStall,
   output logic              ValidE,
   output logic              IllegalE,
   output logic              RegWriteE,
   output logic              MemWriteE,
   output logic              JumpE,
   output logic              JalrE,
   output logic              BranchE,
   output logic              ALUSrcAE,
   output logic              ALUSrcBE,
   output logic [1:0]        ResultSrcE,
   output logic [3:0]        ALUControlE,
   output logic [2:0]        Funct3E,
   output logic [XLEN-1:0]   RD1E,
   output logic [XLEN-1:0]   RD2E,
   output logic [XLEN-1:0]   ImmExtE,
   output logic [XLEN-1:0]   PCE,
   output logic [XLEN-1:0]   PCPlus4E,
   output logic [REG_AW-1:0] Rs1E,
   output logic [REG_AW-1:0] Rs2E,
   output logic [REG_AW-1:0] RdE
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_SLT   = 4'b0101;
   localparam logic [3:0] ALU_SLTU  = 4'b0110;
   localparam logic [3:0] ALU_SLL   = 4'b0111;
   localparam logic [3:0] ALU_SRL   = 4'b1000;
   localparam logic [3:0] ALU_SRA   = 4'b1001;
   localparam logic [3:0] ALU_PASSB = 4'b1010;

   typedef struct packed {
      logic              valid;
      logic              illegal;
      logic              reg_write;
      logic              mem_write;
      logic              jump;
      logic              jalr;
      logic              branch;
      logic              alu_src_a;
      logic              alu_src_b;
      logic [1:0]        result_src;
      logic [3:0]        alu_ctrl;
      logic [2:0]        funct3;
      logic [XLEN-1:0]   rd1;
      logic [XLEN-1:0]   rd2;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   pc_plus4;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
   } idex_t;

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [REG_AW-1:0] rd_fld;
   logic [31:0]       imm_i, imm_s, imm_b, imm_j, imm_u;
   logic [31:0]       imm32;
   logic [3:0]        alu_fn;
   logic              illegal, reg_write, mem_write, jump, jalr, branch;
   logic              alu_src_a, alu_src_b;
   logic [1:0]        result_src;
   logic [3:0]        alu_ctrl;
   logic [XLEN-1:0]   rf_q [NREGS];
   logic              wr_en;
   logic [XLEN-1:0]   rd1, rd2;
   idex_t             dec;
   idex_t             idex_d, idex_q;

   assign opcode = InstrD[6:0];
   assign funct3 = InstrD[14:12];
   assign Rs1D   = REG_AW'(InstrD[19:15]);
   assign Rs2D   = REG_AW'(InstrD[24:20]);
   assign rd_fld = REG_AW'(InstrD[11:7]);

   assign imm_i = {{20{InstrD[31]}}, InstrD[31:20]};
   assign imm_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
   assign imm_b = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
   assign imm_j = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
   assign imm_u = {InstrD[31:12], 12'b0};

   // ALU op for OP / OP-IMM from funct3; subtract only exists in register form
   always_comb begin
      alu_fn = ALU_ADD;
      unique case (funct3)
         3'b000:  alu_fn = (opcode == OPC_OP && InstrD[30]) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_fn = ALU_SLL;
         3'b010:  alu_fn = ALU_SLT;
         3'b011:  alu_fn = ALU_SLTU;
         3'b100:  alu_fn = ALU_XOR;
         3'b101:  alu_fn = InstrD[30] ? ALU_SRA : ALU_SRL;
         3'b110:  alu_fn = ALU_OR;
         default: alu_fn = ALU_AND;
      endcase
   end

   // Main control decode; unknown opcodes leave every side-effecting control low
   always_comb begin
      illegal    = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      jump       = 1'b0;
      jalr       = 1'b0;
      branch     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 1'b0;
      result_src = 2'b00;
      alu_ctrl   = ALU_ADD;
      imm32      = '0;
      case (opcode)
         OPC_LOAD: begin
            reg_write = 1'b1; result_src = 2'b01; alu_src_b = 1'b1; imm32 = imm_i;
         end
         OPC_STORE: begin
            mem_write = 1'b1; alu_src_b = 1'b1; imm32 = imm_s;
         end
         OPC_OP: begin
            reg_write = 1'b1; alu_ctrl = alu_fn;
         end
         OPC_OPIMM: begin
            reg_write = 1'b1; alu_src_b = 1'b1; alu_ctrl = alu_fn; imm32 = imm_i;
         end
         OPC_BRANCH: begin
            branch = 1'b1; alu_ctrl = ALU_SUB; imm32 = imm_b;
         end
         OPC_JAL: begin
            reg_write = 1'b1; jump = 1'b1; result_src = 2'b10; imm32 = imm_j;
         end
         OPC_JALR: begin
            reg_write = 1'b1; jalr = 1'b1; result_src = 2'b10; alu_src_b = 1'b1; imm32 = imm_i;
         end
         OPC_LUI: begin
            reg_write = 1'b1; alu_src_b = 1'b1; alu_ctrl = ALU_PASSB; imm32 = imm_u;
         end
         OPC_AUIPC: begin
            reg_write = 1'b1; alu_src_a = 1'b1; alu_src_b = 1'b1; imm32 = imm_u;
         end
         default: illegal = 1'b1;
      endcase
   end

   assign wr_en = RegWriteW && (RdW != '0);

   // Register file storage; x0 is never written
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else if (wr_en) begin
         rf_q[RdW] <= ResultW;
      end
   end

   // Read ports with write-through so a same-cycle writeback is seen in decode
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (Rs1D != '0) rd1 = (wr_en && RdW == Rs1D) ? ResultW : rf_q[Rs1D];
      if (Rs2D != '0) rd2 = (wr_en && RdW == Rs2D) ? ResultW : rf_q[Rs2D];
   end

   assign LoadUseStall = ValidD && idex_q.valid && (idex_q.result_src == 2'b01) &&
                         (idex_q.rd != '0) && ((idex_q.rd == Rs1D) || (idex_q.rd == Rs2D));

   // Decoded bundle; a non-valid slot becomes an all-zero bubble
   always_comb begin
      dec = '0;
      if (ValidD) begin
         dec.valid      = 1'b1;
         dec.illegal    = illegal;
         dec.reg_write  = reg_write;
         dec.mem_write  = mem_write;
         dec.jump       = jump;
         dec.jalr       = jalr;
         dec.branch     = branch;
         dec.alu_src_a  = alu_src_a;
         dec.alu_src_b  = alu_src_b;
         dec.result_src = result_src;
         dec.alu_ctrl   = alu_ctrl;
         dec.funct3     = funct3;
         dec.rd1        = rd1;
         dec.rd2        = rd2;
         dec.imm        = XLEN'($signed(imm32));
         dec.pc         = PCD;
         dec.pc_plus4   = PCPlus4D;
         dec.rs1        = Rs1D;
         dec.rs2        = Rs2D;
         dec.rd         = rd_fld;
      end
   end

   // ID/EX next value: flush beats hold, hold beats a load-use bubble
   always_comb begin
      idex_d = dec;
      if (FlushE)            idex_d = '0;
      else if (HoldE)        idex_d = idex_q;
      else if (LoadUseStall) idex_d = '0;
   end

   // ID/EX pipeline register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) idex_q <= '0;
      else        idex_q <= idex_d;
   end

   assign ValidE      = idex_q.valid;
   assign IllegalE    = idex_q.illegal;
   assign RegWriteE   = idex_q.reg_write;
   assign MemWriteE   = idex_q.mem_write;
   assign JumpE       = idex_q.jump;
   assign JalrE       = idex_q.jalr;
   assign BranchE     = idex_q.branch;
   assign ALUSrcAE    = idex_q.alu_src_a;
   assign ALUSrcBE    = idex_q.alu_src_b;
   assign ResultSrcE  = idex_q.result_src;
   assign ALUControlE = idex_q.alu_ctrl;
   assign Funct3E     = idex_q.funct3;
   assign RD1E        = idex_q.rd1;
   assign RD2E        = idex_q.rd2;
   assign ImmExtE     = idex_q.imm;
   assign PCE         = idex_q.pc;
   assign PCPlus4E    = idex_q.pc_plus4;
   assign Rs1E        = idex_q.rs1;
   assign Rs2E        = idex_q.rs2;
   assign RdE         = idex_q.rd;

endmodule

// File: tb/tb_decode_stage_hz.sv
`timescale 1ns/1ps
// tb_decode_stage_hz: scoreboard bench with a behavioural decode model.
module tb_decode_stage_hz;

   localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_OP = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

   typedef struct packed {
      logic valid, illegal, regwrite, memwrite, jump, jalr, branch, srca, srcb;
      logic [1:0]  rsrc;
      logic [3:0]  aluc;
      logic [2:0]  f3;
      logic [31:0] rd1, rd2, imm, pc, pc4;
      logic [4:0]  rs1, rs2, rd;
   } ebun_t;

   typedef struct packed {
      ebun_t e;
      logic  imm_dc;
      logic  alu_dc;
   } mst_t;

   typedef struct packed {
      ebun_t e;
      logic  imm_dc;
      logic  alu_dc;
      logic  stall;
   } item_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] rd1, rd2, imm;
   } e64_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
   logic        ValidD, HoldE, FlushE, RegWriteW;
   logic [4:0]  RdW, Rs1D, Rs2D;
   logic        LoadUseStall, ValidE, IllegalE, RegWriteE, MemWriteE, JumpE, JalrE, BranchE;
   logic        ALUSrcAE, ALUSrcBE;
   logic [1:0]  ResultSrcE;
   logic [3:0]  ALUControlE;
   logic [2:0]  Funct3E;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]  Rs1E, Rs2E, RdE;

   decode_stage_hz #(.XLEN(32), .NREGS(32)) u_dut (
      .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .ValidD(ValidD), .HoldE(HoldE), .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW),
      .ResultW(ResultW), .Rs1D(Rs1D), .Rs2D(Rs2D), .LoadUseStall(LoadUseStall),
      .ValidE(ValidE), .IllegalE(IllegalE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
      .JumpE(JumpE), .JalrE(JalrE), .BranchE(BranchE), .ALUSrcAE(ALUSrcAE),
      .ALUSrcBE(ALUSrcBE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
      .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
      .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
   );

   // Second instance at XLEN=64, NREGS=16
   logic [31:0] i64_instr;
   logic [63:0] i64_pc, i64_pc4, i64_res;
   logic        i64_vd, i64_rw;
   logic [3:0]  i64_rdw, o64_rs1d, o64_rs2d;
   logic        o64_stall, o64_valid, o64_ill, o64_rwe, o64_mwe, o64_j, o64_jr, o64_br;
   logic        o64_sa, o64_sb;
   logic [1:0]  o64_rsrc;
   logic [3:0]  o64_aluc;
   logic [2:0]  o64_f3;
   logic [63:0] o64_rd1, o64_rd2, o64_imm, o64_pc, o64_pc4;
   logic [3:0]  o64_rs1, o64_rs2, o64_rd;

   decode_stage_hz #(.XLEN(64), .NREGS(16)) u_dut64 (
      .clk(clk), .reset(reset), .InstrD(i64_instr), .PCD(i64_pc), .PCPlus4D(i64_pc4),
      .ValidD(i64_vd), .HoldE(1'b0), .FlushE(1'b0), .RegWriteW(i64_rw), .RdW(i64_rdw),
      .ResultW(i64_res), .Rs1D(o64_rs1d), .Rs2D(o64_rs2d), .LoadUseStall(o64_stall),
      .ValidE(o64_valid), .IllegalE(o64_ill), .RegWriteE(o64_rwe), .MemWriteE(o64_mwe),
      .JumpE(o64_j), .JalrE(o64_jr), .BranchE(o64_br), .ALUSrcAE(o64_sa),
      .ALUSrcBE(o64_sb), .ResultSrcE(o64_rsrc), .ALUControlE(o64_aluc),
      .Funct3E(o64_f3), .RD1E(o64_rd1), .RD2E(o64_rd2), .ImmExtE(o64_imm), .PCE(o64_pc),
      .PCPlus4E(o64_pc4), .Rs1E(o64_rs1), .Rs2E(o64_rs2), .RdE(o64_rd)
   );

   item_t       q[$];
   e64_t        q64[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] mregs [32];
   mst_t        mcur;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] mread(input logic [4:0] idx, input logic rw,
                                         input logic [4:0] wrd, input logic [31:0] res);
      if (idx == 5'd0) return 32'd0;
      if (rw && wrd != 5'd0 && wrd == idx) return res;
      return mregs[idx];
   endfunction

   // Reference decode: what execute should see one cycle after this instruction
   function automatic mst_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [31:0] r1, input logic [31:0] r2);
      mst_t               m;
      logic signed [31:0] s;
      logic [31:0]        ii, is, ib, ij, iu;
      logic [2:0]         f3;
      logic [3:0]         tab [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
      m = '0;
      s = $signed(ins);
      f3 = ins[14:12];
      ii = 32'(s >>> 20);
      is = (32'(s >>> 20) & 32'hFFFF_FFE0) | 32'(ins[11:7]);
      ib = (32'(s >>> 19) & 32'hFFFF_F000) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) |
           (32'(ins[11:8]) << 1);
      ij = (32'(s >>> 11) & 32'hFFF0_0000) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) |
           (32'(ins[30:21]) << 1);
      iu = ins & 32'hFFFF_F000;
      m.e.valid = 1'b1;
      m.e.f3 = f3;
      m.e.pc = pc;
      m.e.pc4 = pc + 32'd4;
      m.e.rd1 = r1;
      m.e.rd2 = r2;
      m.e.rs1 = ins[19:15];
      m.e.rs2 = ins[24:20];
      m.e.rd = ins[11:7];
      case (ins[6:0])
         OP_LOAD:  begin m.e.regwrite = 1; m.e.rsrc = 2'b01; m.e.srcb = 1; m.e.imm = ii; end
         OP_STORE: begin m.e.memwrite = 1; m.e.srcb = 1; m.e.imm = is; end
         OP_OP: begin
            m.e.regwrite = 1; m.imm_dc = 1; m.e.aluc = tab[f3];
            if (ins[30] && f3 == 3'd0) m.e.aluc = 4'd1;
            if (ins[30] && f3 == 3'd5) m.e.aluc = 4'd9;
         end
         OP_IMM: begin
            m.e.regwrite = 1; m.e.srcb = 1; m.e.imm = ii; m.e.aluc = tab[f3];
            if (ins[30] && f3 == 3'd5) m.e.aluc = 4'd9;
         end
         OP_BR:    begin m.e.branch = 1; m.e.aluc = 4'd1; m.e.imm = ib; end
         OP_JAL:   begin m.e.regwrite = 1; m.e.jump = 1; m.e.rsrc = 2'b10; m.e.imm = ij; end
         OP_JALR: begin
            m.e.regwrite = 1; m.e.jalr = 1; m.e.rsrc = 2'b10; m.e.srcb = 1; m.e.imm = ii;
         end
         OP_LUI:   begin m.e.regwrite = 1; m.e.srcb = 1; m.e.aluc = 4'd10; m.e.imm = iu; end
         OP_AUIPC: begin m.e.regwrite = 1; m.e.srca = 1; m.e.srcb = 1; m.e.imm = iu; end
         default:  begin m.e.illegal = 1; m.imm_dc = 1; m.alu_dc = 1; end
      endcase
      return m;
   endfunction

   // One cycle: drive inputs, queue what E and the stall should show now, advance model
   task automatic step(input logic rst, input logic [31:0] ins, input logic vd, hd, fl,
                       input logic rw, input logic [4:0] wrd, input logic [31:0] res);
      logic [31:0] pc;
      logic        stall;
      mst_t        nxt;
      item_t       it;
      pc = $urandom & 32'hFFFF_FFFC;
      reset = rst; InstrD = ins; ValidD = vd; HoldE = hd; FlushE = fl;
      RegWriteW = rw; RdW = wrd; ResultW = res; PCD = pc; PCPlus4D = pc + 32'd4;
      if (!rst) begin
         mcur = '0;
         for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      end
      stall = rst && vd && mcur.e.valid && mcur.e.rsrc == 2'b01 && mcur.e.rd != 5'd0 &&
              (mcur.e.rd == ins[19:15] || mcur.e.rd == ins[24:20]);
      it.e = mcur.e; it.imm_dc = mcur.imm_dc; it.alu_dc = mcur.alu_dc; it.stall = stall;
      q.push_back(it);
      if (!rst || fl)  nxt = '0;
      else if (hd)     nxt = mcur;
      else if (stall)  nxt = '0;
      else if (!vd)    nxt = '0;
      else nxt = model_decode(ins, pc, mread(ins[19:15], rw, wrd, res),
                              mread(ins[24:20], rw, wrd, res));
      if (rst && rw && wrd != 5'd0) mregs[wrd] = res;
      mcur = nxt;
      @(posedge clk); #1;
   endtask

   task automatic step64(input logic [31:0] ins, input logic vd, input logic rw,
                         input logic [3:0] wrd, input logic [63:0] res, input e64_t cur);
      i64_instr = ins; i64_vd = vd; i64_rw = rw; i64_rdw = wrd; i64_res = res;
      q64.push_back(cur);
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      int          k;
      logic [6:0]  ills [4] = '{7'h7F, 7'h0F, 7'h73, 7'h00};
      r = $urandom;
      k = $urandom_range(0, 11);
      r[11:7]  = 5'($urandom_range(0, 7));
      r[19:15] = 5'($urandom_range(0, 7));
      r[24:20] = 5'($urandom_range(0, 7));
      case (k)
         0, 1, 2: r[6:0] = OP_LOAD;
         3:       r[6:0] = OP_STORE;
         4:       r[6:0] = OP_OP;
         5:       r[6:0] = OP_IMM;
         6:       r[6:0] = OP_BR;
         7:       r[6:0] = OP_JAL;
         8:       r[6:0] = OP_JALR;
         9:       r[6:0] = OP_LUI;
         10:      r[6:0] = OP_AUIPC;
         default: r[6:0] = ills[$urandom_range(0, 3)];
      endcase
      return r;
   endfunction

   // Monitor: compare E bundle and stall against the queued expectation
   item_t mon_it;
   ebun_t mon_act, mon_exp;
   always @(negedge clk) begin
      if (q.size() != 0) begin
         mon_it = q.pop_front();
         mon_exp = mon_it.e;
         mon_act = {ValidE, IllegalE, RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcAE,
                    ALUSrcBE, ResultSrcE, ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, PCE,
                    PCPlus4E, Rs1E, Rs2E, RdE};
         if (mon_it.imm_dc) begin mon_act.imm = '0; mon_exp.imm = '0; end
         if (mon_it.alu_dc) begin
            mon_act.aluc = '0; mon_act.srca = 0; mon_act.srcb = 0; mon_act.rsrc = '0;
            mon_exp.aluc = '0; mon_exp.srca = 0; mon_exp.srcb = 0; mon_exp.rsrc = '0;
         end
         checks++;
         if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL e_bundle cyc %0d got %h want %h", cyc, mon_act, mon_exp);
         end
         checks++;
         if (LoadUseStall !== mon_it.stall) begin
            errors++;
            $display("FAIL load_use_stall cyc %0d got %b want %b", cyc, LoadUseStall,
                     mon_it.stall);
         end
      end
   end

   e64_t mon64_exp, mon64_act;
   always @(negedge clk) begin
      if (q64.size() != 0) begin
         mon64_exp = q64.pop_front();
         mon64_act = {o64_valid, o64_rd1, o64_rd2, o64_imm};
         checks++;
         if (mon64_act !== mon64_exp) begin
            errors++;
            $display("FAIL xlen64 cyc %0d got %h want %h", cyc, mon64_act, mon64_exp);
         end
      end
   end

   localparam logic [31:0] ADD_X6_X4_X2 = 32'h0022_0333;
   localparam logic [31:0] LW_X4        = 32'h0000_A203;

   initial begin
      logic [31:0] beq64, addi64;
      reset = 0; InstrD = '0; ValidD = 0; HoldE = 0; FlushE = 0; RegWriteW = 0; RdW = '0;
      ResultW = '0; PCD = '0; PCPlus4D = '0;
      i64_instr = '0; i64_pc = '0; i64_pc4 = '0; i64_vd = 0; i64_rw = 0; i64_rdw = '0;
      i64_res = '0;
      mcur = '0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      @(posedge clk); #1;

      // reset held with an add in decode and a writeback pending
      repeat (3) step(0, rtype(7'h0, 5'd3, 5'd2, 3'd0, 5'd1, OP_OP), 1, 0, 0, 1, 5'd1, 32'h55);
      // every register reads zero after reset
      for (int i = 1; i < 32; i++)
         step(1, rtype(7'h0, 5'((i % 31) + 1), 5'(i), 3'd0, 5'd1, OP_OP), 1, 0, 0, 0, 5'd0, 0);

      // decode sweep
      step(1, itype(12'hFFF, 5'd0, 3'd0, 5'd5, OP_IMM), 1, 0, 0, 0, 5'd0, 0);
      step(1, {20'h12345, 5'd3, OP_LUI}, 1, 0, 0, 0, 5'd0, 0);
      step(1, 32'h0000_007F, 1, 0, 0, 0, 5'd0, 0);
      step(1, 32'h0000_007F, 0, 0, 0, 0, 5'd0, 0);

      // write-through bypass, and x0 stays zero
      step(1, rtype(7'h0, 5'd0, 5'd7, 3'd0, 5'd8, OP_OP), 1, 0, 0, 1, 5'd7, 32'hDEAD_BEEF);
      step(1, rtype(7'h0, 5'd0, 5'd0, 3'd0, 5'd8, OP_OP), 1, 0, 0, 1, 5'd0, 32'h1234_5678);
      step(1, rtype(7'h0, 5'd7, 5'd7, 3'd0, 5'd9, OP_OP), 1, 0, 0, 0, 5'd0, 0);

      // load-use: stall once, then the add issues
      step(1, LW_X4, 1, 0, 0, 0, 5'd0, 0);
      step(1, ADD_X6_X4_X2, 1, 0, 0, 0, 5'd0, 0);
      step(1, ADD_X6_X4_X2, 1, 0, 0, 0, 5'd0, 0);

      // flush with hold, then hold alone for two cycles
      step(1, itype(12'h123, 5'd7, 3'd0, 5'd9, OP_IMM), 1, 1, 1, 0, 5'd0, 0);
      step(1, itype(12'h123, 5'd7, 3'd0, 5'd9, OP_IMM), 1, 0, 0, 0, 5'd0, 0);
      step(1, {20'hABCDE, 5'd3, OP_LUI}, 1, 1, 0, 0, 5'd0, 0);
      step(1, {20'hABCDE, 5'd3, OP_LUI}, 1, 1, 0, 0, 5'd0, 0);

      // flush during a load-use stall: no duplicate issue
      step(1, LW_X4, 1, 0, 0, 0, 5'd0, 0);
      step(1, ADD_X6_X4_X2, 1, 0, 1, 0, 5'd0, 0);
      step(1, ADD_X6_X4_X2, 1, 0, 0, 0, 5'd0, 0);

      // reset arriving mid-hazard
      step(1, LW_X4, 1, 0, 0, 0, 5'd0, 0);
      step(0, ADD_X6_X4_X2, 1, 0, 0, 0, 5'd0, 0);
      step(1, ADD_X6_X4_X2, 1, 0, 0, 0, 5'd0, 0);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         step((n == 700) ? 1'b0 : 1'b1, rand_instr(), ($urandom % 8) != 0,
              ($urandom % 10) == 0, ($urandom % 12) == 0, ($urandom % 2) == 1,
              5'($urandom % 8), $urandom);
      end
      step(1, 32'd0, 0, 0, 0, 0, 5'd0, 0);

      // 64-bit / 16-register instance
      beq64  = {1'b1, 6'b111111, 5'd15, 5'd15, 3'b000, 4'b1110, 1'b1, OP_BR};
      addi64 = itype(12'h800, 5'd15, 3'd0, 5'd1, OP_IMM);
      step64(beq64, 1, 1, 4'd15, 64'hA5A5_0000_1234_5678, '0);
      step64(addi64, 1, 0, 4'd0, 64'd0,
             {1'b1, 64'hA5A5_0000_1234_5678, 64'hA5A5_0000_1234_5678, 64'hFFFF_FFFF_FFFF_FFFC});
      step64(32'd0, 0, 0, 4'd0, 64'd0,
             {1'b1, 64'hA5A5_0000_1234_5678, 64'd0, 64'hFFFF_FFFF_FFFF_F800});
      step64(32'd0, 0, 0, 4'd0, 64'd0, '0);

      for (int i = 0; i < 10 && (q.size() != 0 || q64.size() != 0); i++) @(negedge clk);
      checks++;
      if (q.size() != 0 || q64.size() != 0) begin
         errors++;
         $display("FAIL drain pending %0d/%0d want 0/0", q.size(), q64.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage_hz.md
# decode_stage_hz

Parametrised RV32I decode stage with integrated register file, load-use hazard detection, and a stallable/flushable ID/EX pipeline register. It sits between the IF/ID register and the execute stage. It decodes the full RV32I base integer set (minus FENCE/SYSTEM), flags illegal opcodes, and produces a one-cycle-latency registered control/data bundle for execute. It inserts bubbles on load-use hazards and squashes on branch/jump redirect.

## Interface
- XLEN, 32: datapath width; immediates sign-extend to XLEN
- NREGS, 32: architectural registers; REG_AW = $clog2(NREGS); register 0 reads zero
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- InstrD  in  32  instruction in decode
- PCD, PCPlus4D  in  XLEN  PC and PC+4 of InstrD
- ValidD  in  1  InstrD is a real instruction (0 = bubble)
- HoldE  in  1  global pipeline stall: ID/EX register keeps its value
- FlushE  in  1  redirect: ID/EX register loads a bubble
- RegWriteW  in  1  writeback enable
- RdW  in  REG_AW  writeback register
- ResultW  in  XLEN  writeback data
- Rs1D, Rs2D  out  REG_AW  source fields (to hazard unit)
- LoadUseStall  out  1  combinational; holds PC and IF/ID, bubbles E
- ValidE, IllegalE  out  1  valid/illegal instruction in E
- RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcAE, ALUSrcBE  out  1  control
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  4  ALU op (see Operation)
- Funct3E  out  3  branch condition / load-store width
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN  data
- Rs1E, Rs2E, RdE  out  REG_AW  register fields

## Operation
- Opcodes: LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. Any other opcode sets IllegalD and forces RegWrite/MemWrite/Jump/Jalr/Branch to 0.
- Immediates: I {inst[31:20]}, S {inst[31:25],inst[11:7]}, B {inst[31],inst[7],inst[30:25],inst[11:8],0}, J {inst[31],inst[19:12],inst[20],inst[30:21],0}, U {inst[31:12],12'b0}. All are sign-extended to XLEN.
- ALUControl codes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu
  - 0111 sll, 1000 srl, 1001 sra, 1010 passB
- ALUControl selection:
  - Sub for OP only, when funct7[5]=1.
  - srai/sra are selected by inst[30].
  - LOAD/STORE/AUIPC/JAL/JALR use add. LUI uses passB. BRANCH uses sub.
- ALUSrcA=1 (PC) for AUIPC only. ALUSrcB=1 (imm) for LOAD, STORE, OP-IMM, JALR, LUI, AUIPC.
- ResultSrc: 01 for LOAD, 10 for JAL/JALR, else 00. RegWrite for LOAD, OP, OP-IMM, JAL, JALR, LUI, AUIPC.
- Register file:
  - NREGS×XLEN flops, all cleared by reset.
  - Write on the rising edge when RegWriteW && RdW!=0.
  - Reads are combinational with write-through bypass: if RegWriteW && RdW!=0 && RdW==Rs, the read returns ResultW.
  - Register 0 always reads 0.
- LoadUseStall = ValidD && ValidE && ResultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D). It is conservative and ignores whether the source is actually used.
- ID/EX register update priority, evaluated each edge:
  1. reset: all E outputs 0.
  2. FlushE: load bubble.
  3. HoldE: keep current value.
  4. LoadUseStall: load bubble.
  5. Otherwise: load decoded values.
- Bubble: ValidE=0, IllegalE=0, all 1-bit controls 0, ResultSrcE=00. Data/field outputs are don't-care; the implementation zeroes them.
- ValidD=0 decodes as a bubble. IllegalE is only set when ValidD=1.

## Timing
- Latency D→E: 1 cycle. RD1E/RD2E capture the bypassed value, so a W write and a D read in the same cycle see new data.
- Reset is asynchronous assert and synchronous deassert (external synchroniser). During reset, all E outputs and registers read 0.
- LoadUseStall is purely combinational from E state and InstrD, with no registered delay. For an unresolved hazard it asserts for exactly one cycle: the next cycle has ValidE=0.
- Simultaneous FlushE and LoadUseStall: a bubble is loaded, and LoadUseStall is still output; upstream flush logic takes precedence.
- Simultaneous FlushE and HoldE: flush wins.
- Reset mid-hazard: the stall drops immediately because ValidE becomes 0.

## Test plan
- Reset: hold reset=0 for 3 cycles with InstrD=add → all E outputs 0, reads of x1..x31 return 0.
- Decode sweep: one instruction per opcode, e.g. `addi x5,x0,-1` → ImmExtE=0xFFFFFFFF, ALUControlE=0000, ALUSrcBE=1, RegWriteE=1. `lui x3,0x12345` → ImmExtE=0x12345000, ALUControlE=1010. Opcode 0x7F → IllegalE=1, RegWriteE=0.
- Bypass: RegWriteW=1, RdW=7, ResultW=0xDEADBEEF with InstrD reading x7 → RD1E=0xDEADBEEF next cycle. The same with RdW=0 → RD1E=0.
- Load-use: `lw x4` in E, `add x6,x4,x2` in D → LoadUseStall=1, next ValidE=0. The following cycle the add is decoded with ValidE=1.
- Flush/hold priority:
  - FlushE=1 & HoldE=1 → bubble.
  - HoldE=1 alone for 2 cycles → E outputs unchanged.
  - FlushE during a load-use stall → bubble, no duplicate issue.
- Parameter sweep: XLEN=64, NREGS=16. A B-type immediate with inst[31]=1 sign-extends to 64 bits. Rd=15 writes and reads correctly.
